// File: rtl/envelope_pkg.sv
// Shared types for the envelope synthesizer: FSM states, the envelope pair
// and the debug view of the control path.
package envelope_pkg;

    localparam int ENV_WIDTH    = 16;
    localparam int ENV_STEP_MIN = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } env_state_t;

    typedef struct packed {
        logic [ENV_WIDTH-1:0] max;
        logic [ENV_WIDTH-1:0] min;
    } env_pair_t;

    typedef struct packed {
        env_state_t state;
        logic       pop;
        logic       fifo_full;
        logic       fifo_empty;
    } env_debug_t;

endpackage

// File: rtl/envelope_fifo.sv
// Synchronous first-word-fall-through FIFO of envelope pairs.
// Synchronous active-high reset empties it; pushes when full and pops when empty are ignored.
module envelope_fifo
    import envelope_pkg::*;
#(
    parameter int  SIZE   = 8,
    parameter type pair_t = env_pair_t,
    localparam int PW     = (SIZE > 1) ? $clog2(SIZE) : 1,
    localparam int CW     = $clog2(SIZE + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  pair_t         wdata,
    input  logic          pop,
    output pair_t         rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    pair_t         mem [SIZE];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(SIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(SIZE));
    assign empty = (count == '0);

endmodule

// File: rtl/envelope_synth.sv
// Triangle-wave synthesizer driven by queued (max, min) envelope pairs.
// Optional ENVELOPE_SYNTH_REPEAT_EN: replay the last pair instead of idling when the queue runs dry.
module envelope_synth
    import envelope_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SIZE  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             env_valid,
    output logic             env_ready,
    input  logic [WIDTH-1:0] env_max,
    input  logic [WIDTH-1:0] env_min,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] dataout,
    output logic             posen,
    output logic             negen,
    output logic             peak,
    output logic             trough,
    output logic             busy,
    output env_debug_t       dbg
);

    localparam int CW = $clog2(SIZE + 1);

    typedef struct packed {
        logic [WIDTH-1:0] max;
        logic [WIDTH-1:0] min;
    } pair_t;

    env_state_t       state;
    env_state_t       state_nxt;
    env_state_t       entry_state;
    logic [WIDTH-1:0] cur_max;
    logic [WIDTH-1:0] cur_min;
    logic [WIDTH-1:0] step_q;

    pair_t            fifo_wdata;
    pair_t            fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             push;
    logic             pop;

    logic [WIDTH:0]   sum;
    logic             rise_hit;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] gap;
    logic             fall_hit;
    logic [WIDTH-1:0] fall_nxt;
    logic             head_swap;
    logic [WIDTH-1:0] new_max;
    logic [WIDTH-1:0] new_min;
    logic [WIDTH-1:0] base;

    // A pair transfers on any edge where env_valid && env_ready; env_ready is
    // held low during reset and while the queue is full, and never depends on env_valid.
    assign env_ready  = !fifo_full && !reset;
    assign push       = env_valid && env_ready;
    assign fifo_wdata = '{max: env_max, min: env_min};

    envelope_fifo #(
        .SIZE   (SIZE),
        .pair_t (pair_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Rise in WIDTH+1 bits so a large step near the top cannot wrap past cur_max.
    assign sum      = {1'b0, dataout} + {1'b0, step_q};
    assign rise_hit = (sum >= {1'b0, cur_max});
    assign rise_nxt = rise_hit ? cur_max : sum[WIDTH-1:0];

    // gap is only meaningful when dataout is above cur_min; the first term covers the rest.
    assign gap      = dataout - cur_min;
    assign fall_hit = (dataout <= cur_min) || (gap <= step_q);
    assign fall_nxt = fall_hit ? cur_min : dataout - step_q;

    assign head_swap = (fifo_rdata.min > fifo_rdata.max);
    assign new_max   = head_swap ? fifo_rdata.min : fifo_rdata.max;
    assign new_min   = head_swap ? fifo_rdata.max : fifo_rdata.min;

    // At a trough dataout is about to become cur_min, so that is the level the next pair starts from.
    assign base        = (state == IDLE) ? dataout : cur_min;
    assign entry_state = (base < new_max) ? RISE : FALL;
    assign pop         = !fifo_empty && ((state == IDLE) || ((state == FALL) && fall_hit));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pop) begin
                    state_nxt = entry_state;
                end
            end
            RISE: begin
                if (rise_hit) begin
                    state_nxt = FALL;
                end
            end
            FALL: begin
                if (fall_hit) begin
                    if (pop) begin
                        state_nxt = entry_state;
                    end else begin
`ifdef ENVELOPE_SYNTH_REPEAT_EN
                        state_nxt = RISE;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        posen = (state == RISE);
        negen = (state == FALL);
        busy  = (state != IDLE) || (fifo_count != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dataout <= '0;
            cur_max <= '0;
            cur_min <= '0;
            step_q  <= WIDTH'(ENV_STEP_MIN);
            peak    <= 1'b0;
            trough  <= 1'b0;
        end else begin
            peak   <= 1'b0;
            trough <= 1'b0;
            case (state)
                RISE: begin
                    dataout <= rise_nxt;
                    peak    <= rise_hit;
                end
                FALL: begin
                    dataout <= fall_nxt;
                    trough  <= fall_hit;
                end
                default: dataout <= dataout;
            endcase
            if (pop) begin
                cur_max <= new_max;
                cur_min <= new_min;
                step_q  <= (step == '0) ? WIDTH'(ENV_STEP_MIN) : step;
            end
        end
    end

    assign dbg = '{state: state, pop: pop, fifo_full: fifo_full, fifo_empty: fifo_empty};

endmodule

// File: tb/tb_envelope_synth.sv
// Directed bench for envelope_synth: per-cycle vector table plus hand-written
// backpressure, reset-abort and repeat-mode sequences.
module tb_envelope_synth;
    import envelope_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         env_valid = 1'b0;
    logic         env_ready;
    logic [W-1:0] env_max = '0;
    logic [W-1:0] env_min = '0;
    logic [W-1:0] step = '0;
    logic [W-1:0] dataout;
    logic         posen, negen, peak, trough, busy;
    env_debug_t   dbg;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_tr_q[$];

    typedef struct {
        bit           rst;
        bit           push;
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic [W-1:0] st;
        logic [W-1:0] d;
        bit           pk;
        bit           tr;
        bit           pe;
        bit           ne;
        bit           bz;
    } row_t;

    row_t rows[$];

    envelope_synth #(.WIDTH(W), .SIZE(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .env_valid (env_valid),
        .env_ready (env_ready),
        .env_max   (env_max),
        .env_min   (env_min),
        .step      (step),
        .dataout   (dataout),
        .posen     (posen),
        .negen     (negen),
        .peak      (peak),
        .trough    (trough),
        .busy      (busy),
        .dbg       (dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        env_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic push_pair(input int mx, input int mn, input int st);
        env_valid = 1'b1;
        env_max   = W'(mx);
        env_min   = W'(mn);
        step      = W'(st);
        tick();
        env_valid = 1'b0;
    endtask

    function automatic void add(input bit rs, input bit pu, input int mx, input int mn, input int st,
                                input int d, input bit pk, input bit tr, input bit pe, input bit ne,
                                input bit bz);
        row_t r;
        r.rst = rs; r.push = pu; r.mx = W'(mx); r.mn = W'(mn); r.st = W'(st);
        r.d = W'(d); r.pk = pk; r.tr = tr; r.pe = pe; r.ne = ne; r.bz = bz;
        rows.push_back(r);
    endfunction

    initial begin
        logic [31:0] act_v;
        logic [31:0] exp_v;
        bit          found;
        int          events;

        // reset held three cycles
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_dataout", i, 32'(dataout), 32'd0);
            check("rst_ready", i, 32'(env_ready), 32'd0);
        end
        reset = 1'b0;
        tick();
        check("post_rst_ready", 0, 32'(env_ready), 32'd1);
        check("post_rst_busy", 0, 32'(busy), 32'd0);
        check("post_rst_state", 0, 32'(dbg.state), 32'(IDLE));

`ifndef ENVELOPE_SYNTH_REPEAT_EN
        // rst push max min step | dataout pk tr pe ne bz
        add(0, 1, 20,  8, 4,   0, 0, 0, 0, 0, 1);
        add(0, 0,  0,  0, 4,   0, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,   4, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,   8, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,  12, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,  16, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,  20, 1, 0, 0, 1, 1);
        add(0, 0,  0,  0, 4,  16, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 4,  12, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 4,   8, 0, 1, 0, 0, 0);
        add(0, 0,  0,  0, 4,   8, 0, 0, 0, 0, 0);
        // clamp at both ends, then step 0 ramps by 1
        add(1, 0,  0,  0, 4,   0, 0, 0, 0, 0, 0);
        add(0, 1, 10,  3, 4,   0, 0, 0, 0, 0, 1);
        add(0, 0,  0,  0, 4,   0, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,   4, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,   8, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 4,  10, 1, 0, 0, 1, 1);
        add(0, 0,  0,  0, 4,   6, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 4,   3, 0, 1, 0, 0, 0);
        add(0, 1,  6,  2, 0,   3, 0, 0, 0, 0, 1);
        add(0, 0,  0,  0, 0,   3, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 9,   4, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 9,   5, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 9,   6, 1, 0, 0, 1, 1);
        add(0, 0,  0,  0, 9,   5, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 9,   4, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 9,   3, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 9,   2, 0, 1, 0, 0, 0);
        // swapped pair behaves as max 30, min 5
        add(1, 0,  0,  0, 5,   0, 0, 0, 0, 0, 0);
        add(0, 1,  5, 30, 5,   0, 0, 0, 0, 0, 1);
        add(0, 0,  0,  0, 5,   0, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,   5, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,  10, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,  15, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,  20, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,  25, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 5,  30, 1, 0, 0, 1, 1);
        add(0, 0,  0,  0, 5,  25, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 5,  20, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 5,  15, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 5,  10, 0, 0, 0, 1, 1);
        add(0, 0,  0,  0, 5,   5, 0, 1, 0, 0, 0);
        // max == min: peak then an immediate trough
        add(1, 0,  0,  0, 2,   0, 0, 0, 0, 0, 0);
        add(0, 1,  7,  7, 2,   0, 0, 0, 0, 0, 1);
        add(0, 0,  0,  0, 2,   0, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 2,   2, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 2,   4, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 2,   6, 0, 0, 1, 0, 1);
        add(0, 0,  0,  0, 2,   7, 1, 0, 0, 1, 1);
        add(0, 0,  0,  0, 2,   7, 0, 1, 0, 0, 0);
        add(0, 0,  0,  0, 2,   7, 0, 0, 0, 0, 0);

        for (int i = 0; i < rows.size(); i++) begin
            reset     = rows[i].rst;
            env_valid = rows[i].push;
            env_max   = rows[i].mx;
            env_min   = rows[i].mn;
            step      = rows[i].st;
            tick();
            exp_v = 32'({rows[i].bz, rows[i].pe, rows[i].ne, rows[i].pk, rows[i].tr, rows[i].d});
            act_v = 32'({busy, posen, negen, peak, trough, dataout});
            check("row", i, act_v, exp_v);
        end
        reset     = 1'b0;
        env_valid = 1'b0;
`else
        begin
            int rep_d  [10] = '{4, 8, 12, 8, 4, 8, 12, 8, 4, 8};
            bit rep_pk [10] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
            bit rep_tr [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
            do_reset();
            push_pair(12, 4, 4);
            tick();
            for (int i = 0; i < 10; i++) begin
                tick();
                check("repeat", i, 32'({peak, trough, dataout}),
                      32'({rep_pk[i], rep_tr[i], W'(rep_d[i])}));
            end
            check("repeat_busy", 0, 32'(busy), 32'd1);
        end
`endif

        // backpressure: long pair in flight, fill the queue, hold a ninth pair
        do_reset();
        push_pair(100, 0, 1);
        tick();
        step = W'(8);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(W'(50 + 5 * i));
            exp_tr_q.push_back(W'(5 * i));
        end
        for (int i = 0; i < 8; i++) begin
            check("ready_before_push", i, 32'(env_ready), 32'd1);
            env_valid = 1'b1;
            env_max   = W'(50 + 5 * i);
            env_min   = W'(5 * i);
            tick();
        end
        env_max = W'(90);
        env_min = W'(40);
        check("ready_full", 0, 32'(env_ready), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            tick();
            if (env_ready) found = 1'b1;
        end
        check("ready_returns", 0, 32'(found), 32'd1);
        check("ready_at_trough", 0, 32'(trough), 32'd1);
        check("ready_at_min", 0, 32'(dataout), 32'd0);
        tick();
        env_valid = 1'b0;
        for (int c = 0; c < 600 && (exp_q.size() > 0 || exp_tr_q.size() > 0); c++) begin
            if (peak) begin
                if (exp_q.size() == 0) check("extra_peak", c, 32'(dataout), 32'hffff_ffff);
                else check("peak_value", c, 32'(dataout), 32'(exp_q.pop_front()));
            end
            if (trough) begin
                if (exp_tr_q.size() == 0) check("extra_trough", c, 32'(dataout), 32'hffff_ffff);
                else check("trough_value", c, 32'(dataout), 32'(exp_tr_q.pop_front()));
            end
            if (exp_q.size() > 0 || exp_tr_q.size() > 0) tick();
        end
        check("replay_left", 0, 32'(exp_q.size() + exp_tr_q.size()), 32'd0);

        // reset while rising with another pair queued
        do_reset();
        env_valid = 1'b1;
        env_max   = W'(30);
        env_min   = W'(5);
        step      = W'(4);
        tick();
        env_max = W'(40);
        env_min = W'(1);
        tick();
        env_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (dataout == W'(12) && posen) found = 1'b1;
            else tick();
        end
        check("reach_12", 0, 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_dataout", 0, 32'(dataout), 32'd0);
        check("abort_pulses", 0, 32'({peak, trough}), 32'd0);
        check("abort_busy", 0, 32'(busy), 32'd0);
        check("abort_ready", 0, 32'(env_ready), 32'd0);
        reset  = 1'b0;
        events = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (peak || trough || busy) events++;
        end
        check("abort_quiet", 0, 32'(events), 32'd0);
        check("abort_hold", 0, 32'(dataout), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/envelope_synth.md
Name: envelope_synth

Overview:
- Inverse of the envelope detector. Accepts a stream of (max, min) envelope pairs and synthesizes a triangle waveform on dataout.
- Ramps up to each max, then down to each min, at a programmable step.
- Emits posen/negen slope flags and peak/trough event pulses, matching the detector's output conventions.
- Used as a stimulus source for detector loopback and as a waveform generator in the datapath.

Parameters:
- WIDTH, 16, sample/envelope width (unsigned).
- SIZE, 8, depth of the envelope-pair FIFO (entries).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- env_valid  input  1  pair offered.
- env_ready  output  1  FIFO can accept a pair.
- env_max  input  WIDTH  target peak value.
- env_min  input  WIDTH  target trough value.
- step  input  WIDTH  ramp increment per cycle; 0 is treated as 1.
- dataout  output  WIDTH  synthesized sample (registered).
- posen  output  1  high while in RISE.
- negen  output  1  high while in FALL.
- peak  output  1  one-cycle pulse on the cycle dataout first equals cur_max.
- trough  output  1  one-cycle pulse on the cycle dataout first equals cur_min.
- busy  output  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (synchronous, when reset=1 at a clk edge):
  - dataout=0, state=IDLE, FIFO emptied.
  - posen, negen, peak and trough all 0.
  - env_ready=0 while reset is high, 1 on the first cycle after.
  - Reset mid-ramp aborts immediately; the in-flight pair and all queued pairs are discarded.
- FIFO:
  - Push when env_valid && env_ready.
  - env_ready = !full.
  - A simultaneous push and pop when full is not permitted (ready is already low). When empty, a push is visible to the pop logic the next cycle.
- Pop/load:
  - A pop occurs in IDLE with FIFO non-empty, or at a trough with FIFO non-empty.
  - On pop, load cur_max = larger of the pair and cur_min = smaller (a swapped pair is corrected).
  - Latch step_q = (step==0) ? 1 : step.
- FSM states: IDLE, RISE, FALL.
- IDLE:
  - dataout holds; posen=negen=0.
  - On pop: next state is RISE if dataout < cur_max, else FALL.
- RISE:
  - posen=1.
  - nxt = dataout + step_q, computed in WIDTH+1 bits, clamped to cur_max.
  - dataout <= nxt.
  - When nxt == cur_max: peak=1 in the cycle dataout becomes cur_max, then go to FALL.
- FALL:
  - negen=1.
  - nxt = dataout - step_q, clamped to cur_min (no underflow below 0).
  - When nxt == cur_min: trough=1 in the same cycle dataout becomes cur_min.
  - After the trough: pop and go to RISE (or FALL if cur_min >= new max) if the FIFO is non-empty, else go to IDLE.
  - If FALL is entered with dataout <= cur_min, dataout is set to cur_min and trough pulses in that cycle.
- Latency: pair accepted at edge t (FIFO empty, IDLE) -> popped at edge t+1 -> first ramp step visible on dataout after edge t+2.
- Entry with dataout >= cur_max goes straight to FALL; no peak pulse.
- cur_max == cur_min: the peak pulse is followed by an immediate trough in the next cycle.
- step is sampled only at pop time; changes mid-pair take effect at the next pair.

Optional Feature:
- Macro: ENVELOPE_SYNTH_REPEAT_EN.
- Defined: at a trough with the FIFO empty, the current pair is reused (go to RISE) instead of entering IDLE. The waveform repeats until a new pair arrives; busy stays 1 after the first pair.
- Undefined: the block enters IDLE and holds dataout at cur_min.

Decomposition:
- Package envelope_pkg holds:
  - state enum env_state_t {IDLE, RISE, FALL}.
  - struct env_pair_t {max, min} of WIDTH.
  - Constant ENV_STEP_MIN = 1.
- One sub-module: envelope_fifo, a synchronous FIFO of env_pair_t, depth SIZE. Ports: push/pop/full/empty/count; reset synchronous and active-high.

Test Plan:
- Reset: hold reset 3 cycles -> dataout=0, env_ready=0 during reset; env_ready=1 and busy=0 afterwards.
- Basic ramp: push (max=20, min=8), step=4, start at 0 -> dataout 4,8,12,16,20 (peak at 20), then 16,12,8 (trough at 8), then IDLE holding 8.
- Clamp: push (max=10, min=3), step=4 from 0 -> dataout 4,8,10 with peak; then 6,3 with trough; step=0 -> ramps by 1.
- Backpressure: while busy, push 8 pairs -> env_ready drops after the 8th; a 9th pair held on env_valid is accepted only after the next pop; all pairs are replayed in order.
- Swapped pair: push (max=5, min=30) -> behaves as max 30, min 5. Reset asserted mid-RISE at dataout=12 -> dataout=0 next cycle, FIFO empty, no peak/trough.
- REPEAT_EN build: single pair (max=12, min=4), step=4 -> 4,8,12,8,4,8,12,... continues without idling.
